gen_burst_ctrl: RTL and testbench

Burst sequencer for the `generator` block. It loads a seed into the generator and enables it for programmed bursts of cycles, separated by idle gaps. It repeats for a programmed number of bursts, then signals completion. It sits between the register or testbench control layer and the generator's load/enable inputs.

---
 rtl/gen_burst_ctrl_if.sv | 41 ++++
 rtl/gen_burst_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_gen_burst_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gen_burst_ctrl_if.sv
// Control/status bundle between the control layer and gen_burst_ctrl.
//
// Signals:
//   start, stop                 : sequence request / abort (control -> sequencer)
//   burst_len, gap_len          : burst and idle-gap lengths in cycles
//   num_bursts                  : bursts per sequence, 0 = run until stop
//   seed_in                     : seed latched on an accepted start
//   gen_load, gen_seed, gen_en  : drive to the generator (sequencer -> generator)
//   busy, done, burst_cnt       : status back to the control layer
//
// Modports:
//   master : control layer side
//   slave  : the sequencer itself
interface gen_burst_ctrl_if #(
  parameter int CNT_W  = 16,
  parameter int SEED_W = 16,
  parameter int NB_W   = 8
);
  logic              start;
  logic              stop;
  logic [CNT_W-1:0]  burst_len;
  logic [CNT_W-1:0]  gap_len;
  logic [NB_W-1:0]   num_bursts;
  logic [SEED_W-1:0] seed_in;
  logic              gen_load;
  logic [SEED_W-1:0] gen_seed;
  logic              gen_en;
  logic              busy;
  logic              done;
  logic [NB_W-1:0]   burst_cnt;

  modport master (
    output start, stop, burst_len, gap_len, num_bursts, seed_in,
    input  gen_load, gen_seed, gen_en, busy, done, burst_cnt
  );

  modport slave (
    input  start, stop, burst_len, gap_len, num_bursts, seed_in,
    output gen_load, gen_seed, gen_en, busy, done, burst_cnt
  );
endinterface

// File: rtl/gen_burst_ctrl.sv
// gen_burst_ctrl: burst sequencer for the generator block.
//
// Loads a seed into the generator, then enables it for bursts of burst_len
// cycles separated by gap_len idle cycles, for num_bursts bursts (0 = until
// stop), and finally pulses done for one cycle.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : gen_burst_ctrl_if.slave (start/stop/config in, generator drive
//           and status out); all outputs are registered.
//
// Build option:
//   GEN_RESEED_EN : when defined, every entry into RUN goes through LOAD, so
//                   each burst restarts the generator from the latched seed
//                   (back-to-back bursts get a one-cycle gen_en gap). When
//                   undefined, the seed is loaded once per sequence.
module gen_burst_ctrl #(
  parameter int CNT_W  = 16,
  parameter int SEED_W = 16,
  parameter int NB_W   = 8
) (
  input  logic           clk,
  input  logic           reset,
  gen_burst_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    GAP  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;

  // Configuration captured on an accepted start.
  logic [CNT_W-1:0]  len_r;
  logic [CNT_W-1:0]  gap_r;
  logic [NB_W-1:0]   nb_r;
  logic [SEED_W-1:0] seed_r;

  // One down-counter serves both RUN and GAP; it is loaded with the full
  // length and the phase ends when it reads 1, so 2^CNT_W-1 needs no extra bit.
  logic [CNT_W-1:0]  cnt;
  logic [NB_W-1:0]   bcnt;

  logic              gen_load_r;
  logic              gen_en_r;
  logic              busy_r;
  logic              done_r;

  logic [NB_W-1:0]   bcnt_inc;
  logic              last_burst;

  // bcnt_inc wraps naturally, which is the required behaviour for num_bursts=0.
  assign bcnt_inc   = bcnt + NB_W'(1);
  assign last_burst = (nb_r != '0) && (bcnt_inc == nb_r);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len_r      <= '0;
      gap_r      <= '0;
      nb_r       <= '0;
      seed_r     <= '0;
      cnt        <= '0;
      bcnt       <= '0;
      gen_load_r <= 1'b0;
      gen_en_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      // Strobes are one cycle wide unless a branch below re-asserts them.
      gen_load_r <= 1'b0;
      done_r     <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            len_r  <= bus.burst_len;
            gap_r  <= bus.gap_len;
            nb_r   <= bus.num_bursts;
            seed_r <= bus.seed_in;
            bcnt   <= '0;
            busy_r <= 1'b1;
            if (bus.burst_len == '0) begin
              state  <= DONE;
              done_r <= 1'b1;
            end else begin
              state      <= LOAD;
              gen_load_r <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (bus.stop) begin
            state    <= DONE;
            done_r   <= 1'b1;
            gen_en_r <= 1'b0;
          end else begin
            state    <= RUN;
            cnt      <= len_r;
            gen_en_r <= 1'b1;
          end
        end

        RUN: begin
          // stop wins even on the final cycle, so an interrupted burst is
          // never counted.
          if (bus.stop) begin
            state    <= DONE;
            done_r   <= 1'b1;
            gen_en_r <= 1'b0;
          end else if (cnt == CNT_W'(1)) begin
            bcnt <= bcnt_inc;
            if (last_burst) begin
              state    <= DONE;
              done_r   <= 1'b1;
              gen_en_r <= 1'b0;
            end else if (gap_r == '0) begin
`ifdef GEN_RESEED_EN
              state      <= LOAD;
              gen_load_r <= 1'b1;
              gen_en_r   <= 1'b0;
`else
              cnt <= len_r;
`endif
            end else begin
              state    <= GAP;
              cnt      <= gap_r;
              gen_en_r <= 1'b0;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        GAP: begin
          if (bus.stop) begin
            state    <= DONE;
            done_r   <= 1'b1;
            gen_en_r <= 1'b0;
          end else if (cnt == CNT_W'(1)) begin
`ifdef GEN_RESEED_EN
            state      <= LOAD;
            gen_load_r <= 1'b1;
`else
            state    <= RUN;
            cnt      <= len_r;
            gen_en_r <= 1'b1;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          state    <= IDLE;
          busy_r   <= 1'b0;
          gen_en_r <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          busy_r   <= 1'b0;
          gen_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gen_load  = gen_load_r;
  assign bus.gen_seed  = seed_r;
  assign bus.gen_en    = gen_en_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.burst_cnt = bcnt;

endmodule

// File: tb/tb_gen_burst_ctrl.sv
// Directed testbench for gen_burst_ctrl. Traces of gen_load/gen_en/done/busy
// are captured cycle by cycle (bit i = i-th cycle after the start edge) and
// compared against hand-computed waveforms. Expectations follow GEN_RESEED_EN.
module tb_gen_burst_ctrl;

  localparam int N = 40;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  gen_burst_ctrl_if bus ();

  gen_burst_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] tr_load, tr_en, tr_done, tr_busy;
  logic [15:0]  seed_at_load;

  function automatic logic [N-1:0] span(input int lo, input int hi);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (i >= lo && i <= hi) r[i] = 1'b1;
    return r;
  endfunction

  // Expected {load, en, done, busy} for the 5/3/2 reference sequence.
  function automatic logic [4*N-1:0] basic_expect();
`ifdef GEN_RESEED_EN
    return {span(0,0) | span(9,9), span(1,5) | span(10,14), span(15,15), span(0,15)};
`else
    return {span(0,0), span(1,5) | span(9,13), span(14,14), span(0,14)};
`endif
  endfunction

  task automatic set_cfg(input logic [15:0] bl, input logic [15:0] gl,
                         input logic [7:0] nb, input logic [15:0] sd);
    bus.burst_len  = bl;
    bus.gap_len    = gl;
    bus.num_bursts = nb;
    bus.seed_in    = sd;
  endtask

  // Pulses start with the current config and records N cycles. stop, a
  // start/config poke, or reset can be asserted during a chosen cycle.
  task automatic run_trace(input int stop_cyc, input int poke_cyc, input int rst_cyc);
    tr_load = '0; tr_en = '0; tr_done = '0; tr_busy = '0;
    seed_at_load = '0;
    bus.start = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      reset     = 1'b0;
      tr_load[i] = bus.gen_load;
      tr_en[i]   = bus.gen_en;
      tr_done[i] = bus.done;
      tr_busy[i] = bus.busy;
      if (i == 0) seed_at_load = bus.gen_seed;
      if (i == stop_cyc) bus.stop = 1'b1;
      if (i == poke_cyc) begin
        bus.start = 1'b1;
        set_cfg(16'd7, 16'd1, 8'd9, 16'h1234);
      end
      if (i == rst_cyc) reset = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.gen_load, bus.gen_en, bus.busy, bus.done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {bus.gen_load, bus.gen_en, bus.busy, bus.done});
    end
    checks++;
    if (bus.gen_seed !== 16'h0000) begin
      failures++;
      $display("FAIL reset_seed got=%h exp=0000", bus.gen_seed);
    end
    checks++;
    if (bus.burst_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_burst_cnt got=%0d exp=0", bus.burst_cnt);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [4*N-1:0] exp_tr;
    set_cfg(16'd5, 16'd3, 8'd2, 16'hACE1);
    run_trace(-1, -1, -1);
    exp_tr = basic_expect();
    checks++;
    if ({tr_load, tr_en, tr_done, tr_busy} !== exp_tr) begin
      failures++;
      $display("FAIL basic_trace got=%h exp=%h", {tr_load, tr_en, tr_done, tr_busy}, exp_tr);
    end
    checks++;
    if (seed_at_load !== 16'hACE1) begin
      failures++;
      $display("FAIL basic_seed got=%h exp=ace1", seed_at_load);
    end
    checks++;
    if (bus.burst_cnt !== 8'd2) begin
      failures++;
      $display("FAIL basic_burst_cnt got=%0d exp=2", bus.burst_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [4*N-1:0] exp_tr;
    set_cfg(16'd4, 16'd0, 8'd3, 16'h0001);
    run_trace(-1, -1, -1);
`ifdef GEN_RESEED_EN
    exp_tr = {span(0,0) | span(5,5) | span(10,10),
              span(1,4) | span(6,9) | span(11,14), span(15,15), span(0,15)};
`else
    exp_tr = {span(0,0), span(1,12), span(13,13), span(0,13)};
`endif
    checks++;
    if ({tr_load, tr_en, tr_done, tr_busy} !== exp_tr) begin
      failures++;
      $display("FAIL b2b_trace got=%h exp=%h", {tr_load, tr_en, tr_done, tr_busy}, exp_tr);
    end
    checks++;
    if (bus.burst_cnt !== 8'd3) begin
      failures++;
      $display("FAIL b2b_burst_cnt got=%0d exp=3", bus.burst_cnt);
    end
  endtask

  task automatic test_stop();
    logic [4*N-1:0] exp_tr;
    set_cfg(16'd2, 16'd2, 8'd0, 16'h0005);
`ifdef GEN_RESEED_EN
    run_trace(12, -1, -1);
    exp_tr = {span(0,0) | span(5,5) | span(10,10),
              span(1,2) | span(6,7) | span(11,12), span(13,13), span(0,13)};
`else
    run_trace(10, -1, -1);
    exp_tr = {span(0,0), span(1,2) | span(5,6) | span(9,10), span(11,11), span(0,11)};
`endif
    checks++;
    if ({tr_load, tr_en, tr_done, tr_busy} !== exp_tr) begin
      failures++;
      $display("FAIL stop_trace got=%h exp=%h", {tr_load, tr_en, tr_done, tr_busy}, exp_tr);
    end
    checks++;
    if (bus.burst_cnt !== 8'd2) begin
      failures++;
      $display("FAIL stop_burst_cnt got=%0d exp=2", bus.burst_cnt);
    end
  endtask

  task automatic test_zero_len();
    logic [4*N-1:0] exp_tr;
    set_cfg(16'd0, 16'd3, 8'd2, 16'h55AA);
    run_trace(-1, -1, -1);
    exp_tr = {{N{1'b0}}, {N{1'b0}}, span(0,0), span(0,0)};
    checks++;
    if ({tr_load, tr_en, tr_done, tr_busy} !== exp_tr) begin
      failures++;
      $display("FAIL zero_len_trace got=%h exp=%h", {tr_load, tr_en, tr_done, tr_busy}, exp_tr);
    end
    checks++;
    if (bus.burst_cnt !== 8'd0) begin
      failures++;
      $display("FAIL zero_len_burst_cnt got=%0d exp=0", bus.burst_cnt);
    end
  endtask

  task automatic test_ignore_busy();
    logic [4*N-1:0] exp_tr;
    set_cfg(16'd5, 16'd3, 8'd2, 16'hACE1);
    run_trace(-1, 3, -1);
    exp_tr = basic_expect();
    checks++;
    if ({tr_load, tr_en, tr_done, tr_busy} !== exp_tr) begin
      failures++;
      $display("FAIL ignore_busy_trace got=%h exp=%h", {tr_load, tr_en, tr_done, tr_busy}, exp_tr);
    end
    checks++;
    if (bus.burst_cnt !== 8'd2) begin
      failures++;
      $display("FAIL ignore_busy_burst_cnt got=%0d exp=2", bus.burst_cnt);
    end
  endtask

  task automatic test_reset_mid_gap();
    logic [4*N-1:0] exp_tr;
    set_cfg(16'd5, 16'd3, 8'd2, 16'hACE1);
    run_trace(-1, -1, 6);
    exp_tr = {span(0,0), span(1,5), {N{1'b0}}, span(0,6)};
    checks++;
    if ({tr_load, tr_en, tr_done, tr_busy} !== exp_tr) begin
      failures++;
      $display("FAIL reset_gap_trace got=%h exp=%h", {tr_load, tr_en, tr_done, tr_busy}, exp_tr);
    end
    checks++;
    if (bus.burst_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_gap_burst_cnt got=%0d exp=0", bus.burst_cnt);
    end
    set_cfg(16'd5, 16'd3, 8'd2, 16'hACE1);
    run_trace(-1, -1, -1);
    exp_tr = basic_expect();
    checks++;
    if ({tr_load, tr_en, tr_done, tr_busy} !== exp_tr) begin
      failures++;
      $display("FAIL restart_trace got=%h exp=%h", {tr_load, tr_en, tr_done, tr_busy}, exp_tr);
    end
  endtask

  task automatic test_max_len();
    int en_cycles;
    bit seen_done;
    en_cycles = 0;
    seen_done = 1'b0;
    set_cfg(16'hFFFF, 16'hFFFF, 8'd1, 16'h0007);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 70000 && !seen_done; i++) begin
      if (bus.gen_en) en_cycles++;
      if (bus.done) seen_done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!seen_done) begin
      failures++;
      $display("FAIL max_len_done got=timeout exp=done");
    end
    checks++;
    if (en_cycles != 65535) begin
      failures++;
      $display("FAIL max_len_en_cycles got=%0d exp=65535", en_cycles);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int stop_cyc;
    bit busy_at_stop;
`ifdef GEN_RESEED_EN
    stop_cyc = 514;
`else
    stop_cyc = 258;
`endif
    busy_at_stop = 1'b0;
    set_cfg(16'd1, 16'd0, 8'd0, 16'h0009);
    bus.start = 1'b1;
    for (int i = 0; i <= stop_cyc + 3; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      if (i == stop_cyc) begin
        busy_at_stop = bus.busy;
        bus.stop = 1'b1;
      end
    end
    checks++;
    if (busy_at_stop !== 1'b1) begin
      failures++;
      $display("FAIL wrap_busy got=%b exp=1", busy_at_stop);
    end
    checks++;
    if (bus.burst_cnt !== 8'd1) begin
      failures++;
      $display("FAIL wrap_burst_cnt got=%0d exp=1", bus.burst_cnt);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_idle got=%b exp=0", bus.busy);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    set_cfg(16'd0, 16'd0, 8'd0, 16'h0000);
    test_reset();
    test_basic();
    test_back_to_back();
    test_stop();
    test_zero_len();
    test_ignore_busy();
    test_reset_mid_gap();
    test_wrap();
    test_max_len();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
